// File: rtl/uart_mmio_tx_if.sv
// Store/load snoop bus between the CPU data path and the UART transmitter.
interface uart_mmio_tx_if;
  logic        is_store;
  logic [3:0]  we;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  modport master (
    output is_store, we, w_addr, w_data, r_addr,
    input  r_data
  );

  modport slave (
    input  is_store, we, w_addr, w_data, r_addr,
    output r_data
  );
endinterface

// File: rtl/uart_mmio_tx.sv
// Memory-mapped 8N1 UART transmitter: snoops byte stores, queues them in a FIFO
// and shifts them out LSB first; exposes a status word on the load path.
module uart_mmio_tx #(
  parameter logic [31:0] UART_ADDR    = 32'hF6FFF070,
  parameter logic [31:0] STAT_ADDR    = 32'hF6FFF074,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_mmio_tx_if.slave    bus,
  output logic             uart_tx,
  output logic             tx_busy,
  output logic             overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud, baud_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [7:0]          shift, shift_n;
  logic                uart_tx_n;

  logic [7:0]          fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count, count_n;
  logic                push, push_ok, pop, full;

  logic                unused_bits;
  assign unused_bits = ^{bus.w_data[31:8], bus.we[3:1]};

  // FIFO bookkeeping: a pop in the same cycle frees the slot a full push needs
  assign push    = bus.is_store & bus.we[0] & (bus.w_addr == UART_ADDR);
  assign full    = (count == CNT_FULL);
  assign push_ok = push & (~full | pop);
  assign count_n = count + CNT_W'(push_ok) - CNT_W'(pop);

  // Status word on the load path; zero for any other address so it can be OR-muxed
  assign bus.r_data = (bus.r_addr == STAT_ADDR)
                    ? {29'b0, overflow, full, tx_busy}
                    : 32'b0;

  // Next-state, baud/bit counters and next line level
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    uart_tx_n = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          shift_n   = fifo[rd_ptr];
          baud_n    = '0;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        uart_tx_n = 1'b0;
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        uart_tx_n = shift[bit_idx];
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_n  = '0;
          state_n = IDLE;
        end else begin
          baud_n = baud + BAUD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      count    <= count_n;
      uart_tx  <= uart_tx_n;
      tx_busy  <= (state_n != IDLE) | (count_n != '0);
      if (pop)            rd_ptr   <= rd_ptr + PTR_W'(1);
      if (push_ok)        wr_ptr   <= wr_ptr + PTR_W'(1);
      if (push & ~push_ok) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) fifo[wr_ptr] <= bus.w_data[7:0];
  end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Self-checking bench for uart_mmio_tx with a cycle-timeline reference model.
module tb_uart_mmio_tx;

  localparam int          C    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] UA   = 32'hF6FFF070;
  localparam logic [31:0] SA   = 32'hF6FFF074;

  logic clk = 1'b0;
  logic rst_n;
  logic uart_tx, tx_busy, overflow;

  uart_mmio_tx_if bus ();

  uart_mmio_tx #(
    .UART_ADDR(UA), .STAT_ADDR(SA), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .uart_tx(uart_tx), .tx_busy(tx_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, each frame described by its pop edge.
  logic [7:0] m_q[$];
  logic [7:0] m_byte;
  int         m_t0;
  bit         m_frame;
  bit         m_ovf;
  bit         m_valid = 0;
  int         n = 0;

  function automatic logic exp_line();
    int k;
    int slot;
    if (!m_frame) return 1'b1;
    k = n - m_t0 - 1;
    if (k < 0 || k >= 10 * C) return 1'b1;
    slot = k / C;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_byte[slot - 1];
  endfunction

  always begin
    bit          pop;
    logic        e_busy, e_full;
    logic [31:0] e_rd;
    @(posedge clk);
    n++;
    if (!rst_n) begin
      m_q.delete();
      m_frame = 0;
      m_ovf   = 0;
      m_valid = 1;
    end else begin
      pop = (!m_frame || n > m_t0 + 10 * C) && (m_q.size() != 0);
      if (pop) begin
        m_byte  = m_q.pop_front();
        m_t0    = n;
        m_frame = 1;
      end
      if (bus.is_store && bus.we[0] && bus.w_addr == UA) begin
        if (m_q.size() < D) m_q.push_back(bus.w_data[7:0]);
        else m_ovf = 1;
      end
    end
    #1;
    if (m_valid) begin
      e_busy = (m_q.size() != 0) || (m_frame && n < m_t0 + 10 * C);
      e_full = (m_q.size() == D);
      e_rd   = (bus.r_addr == SA) ? {29'b0, m_ovf, e_full, e_busy} : 32'b0;
      chk("model_uart_tx", 32'(uart_tx), 32'(exp_line()));
      chk("model_tx_busy", 32'(tx_busy), 32'(e_busy));
      chk("model_overflow", 32'(overflow), 32'(m_ovf));
      chk("model_r_data", bus.r_data, e_rd);
    end
  end

  task automatic drive(input logic st, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.is_store = st;
    bus.we       = w;
    bus.w_addr   = a;
    bus.w_data   = d;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    drive(1'b1, 4'b0001, UA, {24'hC0FFEE, b});
    idle();
  endtask

  // Called right after push_byte on an idle line: samples mid-slot of every bit.
  task automatic check_frame(input string name, input logic [9:0] bits);
    repeat (2) @(posedge clk);
    for (int s = 0; s < 10; s++) begin
      repeat (2) @(posedge clk);
      #1;
      chk(name, 32'(uart_tx), 32'(bits[s]));
      repeat (2) @(posedge clk);
    end
    #1;
    chk({name, "_busy_end"}, 32'(tx_busy), 32'h0);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (tx_busy && c < budget) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    chk("drain_in_budget", 32'(c < budget), 32'h1);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.is_store = 1'b0;
    bus.we       = 4'b0;
    bus.w_addr   = 32'h0;
    bus.w_data   = 32'h0;
    bus.r_addr   = SA;

    // 1. Reset
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 32'h1);
    chk("rst_tx_busy", 32'(tx_busy), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_status", bus.r_data, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2. Single byte A5: start, 1,0,1,0,0,1,0,1, stop (bit 0 first in vector)
    push_byte(8'hA5);
    check_frame("a5_frame", 10'b1_1010_0101_0);
    repeat (3) @(negedge clk);

    // 3. Filtering
    drive(1'b1, 4'b0010, UA, 32'h55);
    drive(1'b1, 4'b0001, UA + 32'd4, 32'h66);
    drive(1'b0, 4'b0001, UA, 32'h77);
    idle();
    bus.r_addr = UA;
    repeat (3) @(negedge clk);
    chk("filter_no_busy", 32'(tx_busy), 32'h0);
    chk("load_uart_addr", bus.r_data, 32'h0);
    bus.r_addr = SA;

    // 4. Burst of five
    for (int i = 1; i <= 5; i++) drive(1'b1, 4'b1111, UA, 32'(i));
    idle();
    chk("burst_full", bus.r_data, 32'h3);
    chk("burst_no_ovf", 32'(overflow), 32'h0);
    wait_idle(400);
    chk("burst_ovf_after", 32'(overflow), 32'h0);

    // 5. Overflow with six pushes
    for (int i = 0; i < 6; i++) drive(1'b1, 4'b0001, UA, 32'h10 + 32'(i));
    idle();
    chk("ovf_status", bus.r_data, 32'h7);
    wait_idle(400);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    chk("ovf_status_drained", bus.r_data, 32'h4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ovf_cleared", 32'(overflow), 32'h0);
    repeat (2) @(negedge clk);

    // 6. Reset during DATA bit 3
    push_byte(8'hF0);
    repeat (17) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_uart_tx", 32'(uart_tx), 32'h1);
    chk("midrst_busy", 32'(tx_busy), 32'h0);
    chk("midrst_status", bus.r_data, 32'h0);
    repeat (2) @(negedge clk);
    push_byte(8'h3C);
    check_frame("post_rst_frame", 10'b1_0011_1100_0);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
